// File: rtl/mult_stream_pipe.sv
// Streaming multiplier: input FIFO -> credit-gated multiply pipeline -> output FIFO.
// Define SIGNED_MULT_EN for a two's-complement product (default build is unsigned).
module mult_stream_pipe #(
  parameter int OPW        = 8,
  parameter int IN_DEPTH   = 16,
  parameter int OUT_DEPTH  = 16,
  parameter int MUL_STAGES = 2
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           WR,
  input  logic [2*OPW-1:0]               DIN,
  output logic                           FULL,
  output logic [$clog2(IN_DEPTH+1)-1:0]  IN_COUNT,
  input  logic                           RD,
  output logic [2*OPW-1:0]               DOUT,
  output logic                           VALID,
  output logic                           EMPTY,
  output logic [$clog2(OUT_DEPTH+1)-1:0] OUT_COUNT,
  output logic                           OVERFLOW,
  output logic                           UNDERFLOW
);

  localparam int DW  = 2 * OPW;
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int ICW = $clog2(IN_DEPTH + 1);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int OCW = $clog2(OUT_DEPTH + 1);

  localparam logic [ICW-1:0] IN_FULL_CNT  = ICW'(IN_DEPTH);
  localparam logic [OCW:0]   OUT_CREDITS  = (OCW + 1)'(OUT_DEPTH);

  // Input FIFO storage and bookkeeping
  logic [DW-1:0]  r_in_mem [IN_DEPTH];
  logic [IAW-1:0] r_in_wptr;
  logic [IAW-1:0] r_in_rptr;
  logic [ICW-1:0] r_in_count;

  // Multiplier pipeline
  logic [OPW-1:0] r_opa;
  logic [OPW-1:0] r_opb;
  logic           r_v0;
  logic [DW-1:0]  r_prod [1:MUL_STAGES];
  logic [MUL_STAGES:1] r_pv;
  logic [OCW-1:0] r_inflight;

  // Output FIFO storage and bookkeeping
  logic [DW-1:0]  r_out_mem [OUT_DEPTH];
  logic [OAW-1:0] r_out_wptr;
  logic [OAW-1:0] r_out_rptr;
  logic [OCW-1:0] r_out_count;

  logic [DW-1:0]  r_dout;
  logic           r_valid;
  logic           r_overflow;
  logic           r_underflow;

  logic           w_in_full;
  logic           w_in_empty;
  logic           w_in_push;
  logic [OCW:0]   w_credit_sum;
  logic           w_credit_ok;
  logic           w_issue;
  logic [DW-1:0]  w_a_ext;
  logic [DW-1:0]  w_b_ext;
  logic [DW-1:0]  w_product;
  logic           w_out_push;
  logic [DW-1:0]  w_out_data;
  logic           w_out_empty;
  logic           w_out_pop;

  assign w_in_full  = (r_in_count == IN_FULL_CNT);
  assign w_in_empty = (r_in_count == '0);
  assign w_in_push  = WR & ~w_in_full;

  // Credits reserve an output slot for every product still in the pipeline.
  assign w_credit_sum = {1'b0, r_out_count} + {1'b0, r_inflight};
  assign w_credit_ok  = (w_credit_sum < OUT_CREDITS);
  assign w_issue      = ~w_in_empty & w_credit_ok;

  assign w_out_push  = r_pv[MUL_STAGES];
  assign w_out_data  = r_prod[MUL_STAGES];
  assign w_out_empty = (r_out_count == '0);
  assign w_out_pop   = RD & ~w_out_empty;

  always_ff @(posedge CLK) begin
    if (w_in_push) begin
      r_in_mem[r_in_wptr] <= DIN;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_in_wptr  <= '0;
      r_in_rptr  <= '0;
      r_in_count <= '0;
    end else begin
      if (w_in_push) begin
        r_in_wptr <= r_in_wptr + IAW'(1);
      end
      if (w_issue) begin
        r_in_rptr <= r_in_rptr + IAW'(1);
      end
      case ({w_in_push, w_issue})
        2'b10:   r_in_count <= r_in_count + ICW'(1);
        2'b01:   r_in_count <= r_in_count - ICW'(1);
        default: r_in_count <= r_in_count;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_opa <= '0;
      r_opb <= '0;
      r_v0  <= 1'b0;
    end else begin
      r_v0 <= w_issue;
      if (w_issue) begin
        {r_opa, r_opb} <= r_in_mem[r_in_rptr];
      end
    end
  end

  // Low 2*OPW bits of the extended product are exact for both signednesses.
`ifdef SIGNED_MULT_EN
  assign w_a_ext = {{OPW{r_opa[OPW-1]}}, r_opa};
  assign w_b_ext = {{OPW{r_opb[OPW-1]}}, r_opb};
`else
  assign w_a_ext = {{OPW{1'b0}}, r_opa};
  assign w_b_ext = {{OPW{1'b0}}, r_opb};
`endif
  assign w_product = w_a_ext * w_b_ext;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int s = 1; s <= MUL_STAGES; s++) begin
        r_prod[s] <= '0;
        r_pv[s]   <= 1'b0;
      end
    end else begin
      r_prod[1] <= w_product;
      r_pv[1]   <= r_v0;
      for (int s = 2; s <= MUL_STAGES; s++) begin
        r_prod[s] <= r_prod[s-1];
        r_pv[s]   <= r_pv[s-1];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_inflight <= '0;
    end else begin
      case ({w_issue, w_out_push})
        2'b10:   r_inflight <= r_inflight + OCW'(1);
        2'b01:   r_inflight <= r_inflight - OCW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_out_push) begin
      r_out_mem[r_out_wptr] <= w_out_data;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_out_wptr  <= '0;
      r_out_rptr  <= '0;
      r_out_count <= '0;
    end else begin
      if (w_out_push) begin
        r_out_wptr <= r_out_wptr + OAW'(1);
      end
      if (w_out_pop) begin
        r_out_rptr <= r_out_rptr + OAW'(1);
      end
      case ({w_out_push, w_out_pop})
        2'b10:   r_out_count <= r_out_count + OCW'(1);
        2'b01:   r_out_count <= r_out_count - OCW'(1);
        default: r_out_count <= r_out_count;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_dout      <= '0;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_valid <= w_out_pop;
      if (w_out_pop) begin
        r_dout <= r_out_mem[r_out_rptr];
      end
      r_overflow  <= r_overflow  | (WR & w_in_full);
      r_underflow <= r_underflow | (RD & w_out_empty);
    end
  end

  assign FULL      = w_in_full;
  assign IN_COUNT  = r_in_count;
  assign DOUT      = r_dout;
  assign VALID     = r_valid;
  assign EMPTY     = w_out_empty;
  assign OUT_COUNT = r_out_count;
  assign OVERFLOW  = r_overflow;
  assign UNDERFLOW = r_underflow;

endmodule

// File: tb/tb_mult_stream_pipe.sv
// Scoreboard bench for mult_stream_pipe: stimulus pushes expected products,
// a negedge monitor pops and compares on every VALID pulse.
module tb_mult_stream_pipe;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        WR  = 1'b0;
  logic        RD  = 1'b0;
  logic [15:0] DIN = '0;
  logic        FULL;
  logic [4:0]  IN_COUNT;
  logic [15:0] DOUT;
  logic        VALID;
  logic        EMPTY;
  logic [4:0]  OUT_COUNT;
  logic        OVERFLOW;
  logic        UNDERFLOW;

  int          vecCount = 0;
  int          errCount = 0;
  int          popCount = 0;
  logic [15:0] expQ[$];
  logic [15:0] lastExp = '0;

  mult_stream_pipe #(
    .OPW(8), .IN_DEPTH(16), .OUT_DEPTH(16), .MUL_STAGES(2)
  ) dut (
    .CLK(CLK), .RST(RST), .WR(WR), .DIN(DIN), .FULL(FULL), .IN_COUNT(IN_COUNT),
    .RD(RD), .DOUT(DOUT), .VALID(VALID), .EMPTY(EMPTY), .OUT_COUNT(OUT_COUNT),
    .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] expProd(input logic [15:0] d);
    int a;
    int b;
`ifdef SIGNED_MULT_EN
    a = $signed(d[15:8]);
    b = $signed(d[7:0]);
`else
    a = int'(d[15:8]);
    b = int'(d[7:0]);
`endif
    return 16'(a * b);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs; the expected product is queued only if the write is accepted.
  task automatic applyStimulus(input logic wr, input logic [15:0] din, input logic rd,
                               input logic [15:0] expected);
    WR  = wr;
    DIN = din;
    RD  = rd;
    if (wr && !FULL) expQ.push_back(expected);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_dout"}, DOUT, 0);
    checkOutput({tag, "_valid"}, VALID, 0);
    checkOutput({tag, "_full"}, FULL, 0);
    checkOutput({tag, "_empty"}, EMPTY, 1);
    checkOutput({tag, "_inCount"}, IN_COUNT, 0);
    checkOutput({tag, "_outCount"}, OUT_COUNT, 0);
    checkOutput({tag, "_overflow"}, OVERFLOW, 0);
    checkOutput({tag, "_underflow"}, UNDERFLOW, 0);
  endtask

  task automatic waitOutCount(input string name, input int target, input int maxCycles);
    int n = 0;
    while (OUT_COUNT != 5'(target) && n < maxCycles) begin
      idle(1);
      n++;
    end
    checkOutput(name, OUT_COUNT, target);
  endtask

  // Monitor: every VALID pulse must match the oldest outstanding expected product.
  always @(negedge CLK) begin
    if (RST === 1'b1 && VALID === 1'b1) begin
      if (expQ.size() == 0) begin
        vecCount++;
        errCount++;
        $display("[TB] FAIL unexpectedValid: got DOUT=%0h, expected no output", DOUT);
      end else begin
        lastExp = expQ.pop_front();
        popCount++;
        checkOutput("scoreboardDout", DOUT, lastExp);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wrN;
    int rdN;
    int stalls;
    int cyc;
    int popBase;
    logic started;
    logic doWr;
    logic doRd;
    logic [15:0] w;

    #1 RST = 1'b0;
    #2 checkResetState("reset");
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;

    // Latency: write at E0, output FIFO non-empty only after E0+4.
    applyStimulus(1'b1, 16'h0304, 1'b0, 16'h000C);
    idle(3);
    checkOutput("latencyEmptyE3", EMPTY, 1);
    idle(1);
    checkOutput("latencyEmptyE4", EMPTY, 0);
    checkOutput("latencyOutCount", OUT_COUNT, 1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 16'h0000);
    checkOutput("firstValid", VALID, 1);
    checkOutput("firstDout", DOUT, 16'h000C);
    idle(1);
    checkOutput("validOneCycle", VALID, 0);

    // Extreme operand values
`ifdef SIGNED_MULT_EN
    applyStimulus(1'b1, 16'hFFFF, 1'b0, 16'h0001);
    applyStimulus(1'b1, 16'h80FF, 1'b0, 16'h0080);
`else
    applyStimulus(1'b1, 16'hFFFF, 1'b0, 16'hFE01);
    applyStimulus(1'b1, 16'h80FF, 1'b0, 16'h7F80);
`endif
    waitOutCount("extremeFill", 2, 20);
    applyStimulus(1'b0, 16'h0000, 1'b1, 16'h0000);
    applyStimulus(1'b0, 16'h0000, 1'b1, 16'h0000);
    idle(1);
    checkOutput("extremeDrained", expQ.size(), 0);

    // Fill both FIFOs, then overflow
    for (int i = 0; i < 32; i++) begin
      w = {8'(i + 1), 8'(3 * i + 2)};
      applyStimulus(1'b1, w, 1'b0, expProd(w));
    end
    idle(1);
    waitOutCount("fillOutCount", 16, 20);
    checkOutput("fillInCount", IN_COUNT, 16);
    checkOutput("fillFull", FULL, 1);
    checkOutput("fillNoOverflowYet", OVERFLOW, 0);
    applyStimulus(1'b1, 16'hABCD, 1'b0, expProd(16'hABCD));
    checkOutput("droppedInCount", IN_COUNT, 16);
    checkOutput("overflowSet", OVERFLOW, 1);
    popBase = popCount;
    repeat (32) applyStimulus(1'b0, 16'h0000, 1'b1, 16'h0000);
    checkOutput("drainEmpty", EMPTY, 1);
    idle(1);
    checkOutput("drainPops", popCount - popBase, 32);
    checkOutput("drainQueue", expQ.size(), 0);
    checkOutput("drainNoUnderflow", UNDERFLOW, 0);

    // Read while empty
    applyStimulus(1'b0, 16'h0000, 1'b1, 16'h0000);
    checkOutput("underflowValid", VALID, 0);
    checkOutput("underflowDoutHeld", DOUT, lastExp);
    checkOutput("underflowSet", UNDERFLOW, 1);
    idle(3);
    checkOutput("underflowSticky", UNDERFLOW, 1);
    checkOutput("overflowSticky", OVERFLOW, 1);

    RST = 1'b0;
    #1 checkResetState("flagReset");
    expQ.delete();
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;

    // Continuous streaming of 100 random words
    wrN = 0; rdN = 0; stalls = 0; cyc = 0; started = 1'b0;
    while ((wrN < 100 || rdN < 100) && cyc < 500) begin
      doWr = (wrN < 100);
      doRd = !EMPTY && (rdN < 100);
      if (doWr && FULL) stalls++;
      if (doRd) started = 1'b1;
      else if (started && rdN < 100) stalls++;
      w = 16'($urandom);
      if (doWr && !FULL) wrN++;
      if (doRd) rdN++;
      applyStimulus(doWr, w, doRd, expProd(w));
      cyc++;
    end
    idle(1);
    checkOutput("streamWrites", wrN, 100);
    checkOutput("streamReads", rdN, 100);
    checkOutput("streamStalls", stalls, 0);
    checkOutput("streamQueue", expQ.size(), 0);
    checkOutput("streamOverflow", OVERFLOW, 0);
    checkOutput("streamUnderflow", UNDERFLOW, 0);

    // Asynchronous reset with words in flight
    for (int i = 0; i < 5; i++) begin
      w = {8'(i + 2), 8'(i + 9)};
      applyStimulus(1'b1, w, 1'b0, expProd(w));
    end
    WR = 1'b0;
    #2 RST = 1'b0;
    #1 checkResetState("midReset");
    expQ.delete();
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    popBase = popCount;
    applyStimulus(1'b1, 16'h0202, 1'b0, 16'h0004);
    waitOutCount("postResetFill", 1, 10);
    applyStimulus(1'b0, 16'h0000, 1'b1, 16'h0000);
    checkOutput("postResetDout", DOUT, 16'h0004);
    idle(8);
    checkOutput("postResetPops", popCount - popBase, 1);
    checkOutput("postResetOutCount", OUT_COUNT, 0);
    checkOutput("postResetInCount", IN_COUNT, 0);
    checkOutput("postResetQueue", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule

// File: doc/mult_stream_pipe.md
Name: mult_stream_pipe

Overview:
Parametrised successor to the two-FIFO multiply stream block. An input FIFO accepts packed operand pairs. A pipelined multiplier with credit-based flow control forms their product. An output FIFO buffers the results for the downstream reader. It adds configurable operand width, FIFO depths and multiplier latency, occupancy outputs, and sticky error flags.

Parameters:
OPW, 8, operand width; DIN carries two operands, DOUT carries the 2*OPW product
IN_DEPTH, 16, input FIFO entries (power of 2, >=4)
OUT_DEPTH, 16, output FIFO entries (power of 2, >=4)
MUL_STAGES, 2, multiplier pipeline register stages (>=1)

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  reset, asynchronous, active-low
WR  in  1  write request, input side
DIN  in  2*OPW  operands: a = DIN[2*OPW-1:OPW], b = DIN[OPW-1:0]
FULL  out  1  input FIFO full
IN_COUNT  out  $clog2(IN_DEPTH+1)  input FIFO occupancy
RD  in  1  read request, output side
DOUT  out  2*OPW  product, registered
VALID  out  1  DOUT valid, one-cycle pulse per accepted read
EMPTY  out  1  output FIFO empty
OUT_COUNT  out  $clog2(OUT_DEPTH+1)  output FIFO occupancy
OVERFLOW  out  1  sticky: WR while FULL
UNDERFLOW  out  1  sticky: RD while EMPTY

Behaviour:
- Reset (RST=0, async) sets the following, clears all pointers, counters and pipeline valid bits, and discards data:
  - DOUT=0, VALID=0, FULL=0, EMPTY=1, IN_COUNT=0, OUT_COUNT=0, OVERFLOW=0, UNDERFLOW=0.
- Input write: accepted at the edge when WR=1 and FULL=0. FULL is 1 exactly when IN_COUNT==IN_DEPTH.
  - FULL is based on pre-edge occupancy, so WR while FULL is dropped even if an internal read occurs in the same cycle. That case sets OVERFLOW.
- Issue: internal read from the input FIFO when the input FIFO is non-empty AND OUT_COUNT + inflight < OUT_DEPTH.
  - inflight counts products issued but not yet written to the output FIFO: +1 on issue, -1 on output write, both may occur in one cycle.
  - The credit check uses pre-edge OUT_COUNT (a same-cycle RD is not credited). Output FIFO overflow is therefore impossible and no data is ever dropped internally.
- Pipeline:
  - Issue edge loads the operand register (stage 0).
  - Stages 1..MUL_STAGES register the product, with the multiply between stage 0 and stage 1.
  - The valid bit travels with the data. Stages never stall; the credit scheme makes stalling unnecessary.
  - The last stage writes to the output FIFO at the next edge.
- Latency: a word written at edge E0 appears in the output FIFO (EMPTY=0, OUT_COUNT incremented) after edge E0+2+MUL_STAGES, provided credit is available.
- Output read: RD=1 and EMPTY=0 pops at the edge. DOUT is updated and VALID=1 for that one cycle only.
  - RD while EMPTY: no pop, VALID=0, DOUT holds its value, UNDERFLOW set.
  - Simultaneous internal write and RD on the output FIFO: OUT_COUNT unchanged, data stays ordered.
- Ordering: strict FIFO end to end.
- Pointers wrap modulo depth. Counts are exact, 0..DEPTH.
- Arithmetic: the product is exactly 2*OPW bits with no truncation. Default is unsigned.
- OVERFLOW and UNDERFLOW clear only on reset.
- Reset mid-operation: all in-flight and buffered data is lost. The first word written after reset release behaves as from the idle state.

Optional Feature:
SIGNED_MULT_EN
- Defined: a and b are two's complement, and the product is the signed 2*OPW-bit result.
- Undefined: a and b are unsigned, and the product is unsigned.
- Flow control and latency are identical in both builds.

Test Plan:
- Defaults, reset, WR with DIN=16'h0304 at edge E0 -> EMPTY falls after E0+4. RD then gives DOUT=16'h000C, VALID=1 for exactly one cycle.
- DIN=16'hFFFF and 16'h80FF:
  - Unsigned build: DOUT=16'hFE01, then 16'h7F80.
  - With SIGNED_MULT_EN: DOUT=16'h0001, then 16'h0080.
- Write 32 distinct words, RD=0 -> OUT_COUNT=16, IN_COUNT=16, FULL=1.
  - A 33rd WR is dropped and OVERFLOW=1.
  - Then RD continuously -> 32 products in write order, ending with EMPTY=1.
- RD while EMPTY=1 -> VALID=0, DOUT unchanged, UNDERFLOW=1, stays 1 until reset.
- Continuous WR and RD, 100 random words -> no FULL or EMPTY stalls after fill, no flag set, every product matches the model.
- RST=0 asynchronously while 5 words are in flight -> all outputs return to reset values immediately. Post-reset write of 16'h0202 -> DOUT=16'h0004 only.
